// File: rtl/memmu_cr_write_scheduler_if.sv
// Signal bundle between the CR write scheduler and the control plane, SIU, CR unit and memory.
// master = scheduler side, slave = surrounding environment.
interface memmu_cr_write_scheduler_if #(
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned CR_ADDR_W = 19;
  localparam int unsigned DATA_W    = 64;

  logic                 i_CTRL_start;
  logic [ADDR_W-1:0]    i_CTRL_baseAddr;
  logic                 i_SIU_valid;
  logic                 i_SIU_frameEnd;
  logic                 o_SIU_ready;
  logic [CR_ADDR_W-1:0] i_MemMU_CR_address;
  logic [DATA_W-1:0]    i_MemMU_CR_payload;
  logic                 o_MEM_wrValid;
  logic                 i_MEM_wrReady;
  logic [ADDR_W-1:0]    o_MEM_wrAddr;
  logic [DATA_W-1:0]    o_MEM_wrData;
  logic                 o_CTRL_busy;
  logic                 o_CTRL_done;
  logic [CR_ADDR_W-1:0] o_CTRL_pointCount;
  logic [CR_ADDR_W-1:0] o_CTRL_dropCount;

  modport master (
    input  i_CTRL_start, i_CTRL_baseAddr,
    input  i_SIU_valid, i_SIU_frameEnd,
    output o_SIU_ready,
    input  i_MemMU_CR_address, i_MemMU_CR_payload,
    output o_MEM_wrValid, o_MEM_wrAddr, o_MEM_wrData,
    input  i_MEM_wrReady,
    output o_CTRL_busy, o_CTRL_done, o_CTRL_pointCount, o_CTRL_dropCount
  );

  modport slave (
    output i_CTRL_start, i_CTRL_baseAddr,
    output i_SIU_valid, i_SIU_frameEnd,
    input  o_SIU_ready,
    output i_MemMU_CR_address, i_MemMU_CR_payload,
    input  o_MEM_wrValid, o_MEM_wrAddr, o_MEM_wrData,
    output i_MEM_wrReady,
    input  o_CTRL_busy, o_CTRL_done, o_CTRL_pointCount, o_CTRL_dropCount
  );
endinterface

// File: rtl/memmu_cr_write_scheduler.sv
// Frame-level write scheduler: gates SIU points into the CR unit, buffers the CR unit's
// {address, payload} one cycle later and issues ordered 64-bit memory writes.
module memmu_cr_write_scheduler #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned NUM_POINTS = 524287
) (
  input  logic                        i_SYSTEM_clk,
  input  logic                        i_SYSTEM_rst,
  memmu_cr_write_scheduler_if.master  bus
);
  localparam int unsigned CR_ADDR_W = 19;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [CR_ADDR_W-1:0] CNT_MAX      = '1;
  localparam logic [CR_ADDR_W:0]   NUM_POINTS_L = (CR_ADDR_W+1)'(NUM_POINTS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  state_t               state;
  logic [ADDR_W-1:0]    base_q;
  logic [CR_ADDR_W-1:0] point_cnt;
  logic [CR_ADDR_W-1:0] drop_cnt;
  logic                 busy_q;
  logic                 done_q;
  logic                 inflight;

  wr_entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     occ;

  logic [CNT_W:0]       occ_sum_c;
  logic                 siu_ready_c;
  logic                 accept_c;
  logic                 in_range_c;
  logic                 push_c;
  logic                 pop_c;
  logic                 fifo_empty_c;
  logic [ADDR_W-1:0]    wr_addr_c;

  // A point in flight through the CR unit already owns a FIFO slot.
  assign occ_sum_c    = {1'b0, occ} + (CNT_W+1)'(inflight);
  assign siu_ready_c  = (state == ST_RUN) && (occ_sum_c < (CNT_W+1)'(FIFO_DEPTH));
  assign accept_c     = bus.i_SIU_valid && siu_ready_c;
  assign in_range_c   = {1'b0, bus.i_MemMU_CR_address} < NUM_POINTS_L;
  assign push_c       = inflight && in_range_c;
  assign fifo_empty_c = (occ == '0);
  assign pop_c        = !fifo_empty_c && bus.i_MEM_wrReady;
  assign wr_addr_c    = base_q + ADDR_W'({bus.i_MemMU_CR_address, 3'b000});

  // Frame control FSM with the control-plane outputs.
  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      state     <= ST_IDLE;
      base_q    <= '0;
      point_cnt <= '0;
      drop_cnt  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_CTRL_start) begin
            state     <= ST_RUN;
            base_q    <= bus.i_CTRL_baseAddr;
            point_cnt <= '0;
            drop_cnt  <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept_c && bus.i_SIU_frameEnd) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!inflight && fifo_empty_c) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
      // Accepts only happen in RUN and drops only resolve in RUN/DRAIN, so these never race the clear.
      if (accept_c && (point_cnt != CNT_MAX)) point_cnt <= point_cnt + 1'b1;
      if (inflight && !in_range_c && (drop_cnt != CNT_MAX)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Show-ahead write buffer; entries carry the final memory address.
  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
    end else begin
      inflight <= accept_c;
      if (push_c) begin
        fifo_mem[wr_ptr] <= '{addr: wr_addr_c, data: bus.i_MemMU_CR_payload};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop_c) rd_ptr <= rd_ptr + 1'b1;
      case ({push_c, pop_c})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign bus.o_SIU_ready       = siu_ready_c;
  assign bus.o_MEM_wrValid     = !fifo_empty_c;
  assign bus.o_MEM_wrAddr      = fifo_mem[rd_ptr].addr;
  assign bus.o_MEM_wrData      = fifo_mem[rd_ptr].data;
  assign bus.o_CTRL_busy       = busy_q;
  assign bus.o_CTRL_done       = done_q;
  assign bus.o_CTRL_pointCount = point_cnt;
  assign bus.o_CTRL_dropCount  = drop_cnt;

endmodule

// File: tb/tb_memmu_cr_write_scheduler.sv
// Directed bench for the CR write scheduler: SIU source queue, CR-unit model and a write scoreboard.
module tb_memmu_cr_write_scheduler;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned NUM_POINTS = 16;

  typedef struct {
    logic [18:0] cr;
    logic [63:0] pay;
    logic        fe;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  beat_t src_q[$];
  exp_t  sb[$];

  logic [31:0] exp_base;
  int          acc_cnt;
  int          wr_cnt;
  int          done_cnt;
  logic        prev_stall;
  logic [31:0] prev_addr;
  logic [63:0] prev_data;

  memmu_cr_write_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  memmu_cr_write_scheduler #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W),
    .NUM_POINTS (NUM_POINTS)
  ) dut (
    .i_SYSTEM_clk (clk),
    .i_SYSTEM_rst (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: present the head beat, score any write handshake, then play the CR unit.
  task automatic tick();
    logic  acc;
    logic  wr;
    beat_t b;
    exp_t  e;
    if (src_q.size() > 0) begin
      bus.i_SIU_valid    = 1'b1;
      bus.i_SIU_frameEnd = src_q[0].fe;
    end else begin
      bus.i_SIU_valid    = 1'b0;
      bus.i_SIU_frameEnd = 1'b0;
    end
    if (prev_stall && bus.o_MEM_wrValid)
      chk("wr_stable", {bus.o_MEM_wrAddr, bus.o_MEM_wrData}, {prev_addr, prev_data});
    acc        = bus.i_SIU_valid && bus.o_SIU_ready;
    wr         = bus.o_MEM_wrValid && bus.i_MEM_wrReady;
    prev_stall = bus.o_MEM_wrValid && !bus.i_MEM_wrReady;
    prev_addr  = bus.o_MEM_wrAddr;
    prev_data  = bus.o_MEM_wrData;
    if (wr) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        chk("wr_unexpected", 96'(sb.size()), 96'd1);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 96'(bus.o_MEM_wrAddr), 96'(e.addr));
        chk("wr_data", 96'(bus.o_MEM_wrData), 96'(e.data));
      end
    end
    if (acc) begin
      b = src_q.pop_front();
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      bus.i_MemMU_CR_address = b.cr;
      bus.i_MemMU_CR_payload = b.pay;
    end else begin
      bus.i_MemMU_CR_address = 19'h3;
      bus.i_MemMU_CR_payload = {32'hBAD0_0000, $urandom};
    end
    if (bus.o_CTRL_done) done_cnt++;
  endtask

  task automatic add_beat(input logic [18:0] cr, input logic [63:0] pay, input logic fe);
    src_q.push_back('{cr: cr, pay: pay, fe: fe});
    if (32'(cr) < NUM_POINTS)
      sb.push_back('{addr: exp_base + (ADDR_W'(cr) << 3), data: pay});
  endtask

  task automatic start_frame(input logic [31:0] base);
    bus.i_CTRL_baseAddr = base;
    bus.i_CTRL_start    = 1'b1;
    tick();
    bus.i_CTRL_start    = 1'b0;
    exp_base = base;
    acc_cnt  = 0;
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (bus.o_CTRL_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 96'(bus.o_CTRL_done), 96'd1);
  endtask

  initial begin
    rst_n                  = 1'b0;
    bus.i_CTRL_start       = 1'b0;
    bus.i_CTRL_baseAddr    = '0;
    bus.i_SIU_valid        = 1'b0;
    bus.i_SIU_frameEnd     = 1'b0;
    bus.i_MemMU_CR_address = '0;
    bus.i_MemMU_CR_payload = '0;
    bus.i_MEM_wrReady      = 1'b1;
    exp_base   = '0;
    acc_cnt    = 0;
    wr_cnt     = 0;
    done_cnt   = 0;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_ready",  96'(bus.o_SIU_ready), 96'd0);
    chk("rst_wrvalid", 96'(bus.o_MEM_wrValid), 96'd0);
    chk("rst_wraddr", 96'(bus.o_MEM_wrAddr), 96'd0);
    chk("rst_busy",   96'(bus.o_CTRL_busy), 96'd0);
    chk("rst_done",   96'(bus.o_CTRL_done), 96'd0);
    chk("rst_pcount", 96'(bus.o_CTRL_pointCount), 96'd0);
    chk("rst_dcount", 96'(bus.o_CTRL_dropCount), 96'd0);

    // Single point: write at t+2, done at t+4
    start_frame(32'h1000_0000);
    chk("t1_busy", 96'(bus.o_CTRL_busy), 96'd1);
    chk("t1_ready", 96'(bus.o_SIU_ready), 96'd1);
    add_beat(19'd5, 64'h0123_4567_89AB_CDEF, 1'b1);
    tick();
    chk("t1_wrvalid_t1", 96'(bus.o_MEM_wrValid), 96'd0);
    tick();
    chk("t1_wrvalid_t2", 96'(bus.o_MEM_wrValid), 96'd1);
    chk("t1_wraddr_t2", 96'(bus.o_MEM_wrAddr), 96'h1000_0028);
    tick();
    chk("t1_done_t3", 96'(bus.o_CTRL_done), 96'd0);
    tick();
    chk("t1_done_t4", 96'(bus.o_CTRL_done), 96'd1);
    chk("t1_pcount", 96'(bus.o_CTRL_pointCount), 96'd1);
    chk("t1_dcount", 96'(bus.o_CTRL_dropCount), 96'd0);
    tick();
    chk("t1_done_t5", 96'(bus.o_CTRL_done), 96'd0);
    chk("t1_busy_idle", 96'(bus.o_CTRL_busy), 96'd0);
    chk("t1_pcount_hold", 96'(bus.o_CTRL_pointCount), 96'd1);
    chk("t1_sb_empty", 96'(sb.size()), 96'd0);

    // Backpressure: 20 points, memory stalled, ignored start while RUN
    bus.i_MEM_wrReady = 1'b0;
    start_frame(32'h2000_0000);
    for (int i = 0; i < 20; i++)
      add_beat(19'(i % 16), {32'hB0B0_0000 + 32'(i), $urandom}, (i == 19));
    repeat (14) tick();
    chk("bp_accepted", 96'(acc_cnt), 96'(FIFO_DEPTH));
    chk("bp_ready_low", 96'(bus.o_SIU_ready), 96'd0);
    chk("bp_wrvalid", 96'(bus.o_MEM_wrValid), 96'd1);
    chk("bp_pcount_mid", 96'(bus.o_CTRL_pointCount), 96'(FIFO_DEPTH));
    bus.i_CTRL_baseAddr = 32'hDEAD_0000;
    bus.i_CTRL_start    = 1'b1;
    tick();
    bus.i_CTRL_start    = 1'b0;
    chk("bp_start_ignored_pcount", 96'(bus.o_CTRL_pointCount), 96'(FIFO_DEPTH));
    chk("bp_start_ignored_busy", 96'(bus.o_CTRL_busy), 96'd1);
    bus.i_MEM_wrReady = 1'b1;
    wait_done("bp_done", 200);
    chk("bp_pcount", 96'(bus.o_CTRL_pointCount), 96'd20);
    chk("bp_dcount", 96'(bus.o_CTRL_dropCount), 96'd0);
    chk("bp_writes", 96'(wr_cnt), 96'd20);
    chk("bp_sb_empty", 96'(sb.size()), 96'd0);
    repeat (5) tick();
    chk("bp_done_once", 96'(done_cnt), 96'd1);
    chk("bp_pcount_hold", 96'(bus.o_CTRL_pointCount), 96'd20);

    // Out of range at the NUM_POINTS boundary
    start_frame(32'h3000_0000);
    add_beat(19'd3,  64'h3333_0000_0000_0003, 1'b0);
    add_beat(19'd16, 64'h3333_0000_0000_0016, 1'b0);
    add_beat(19'd15, 64'h3333_0000_0000_0015, 1'b1);
    wait_done("oor_done", 50);
    chk("oor_dcount", 96'(bus.o_CTRL_dropCount), 96'd1);
    chk("oor_pcount", 96'(bus.o_CTRL_pointCount), 96'd3);
    chk("oor_writes", 96'(wr_cnt), 96'd2);
    chk("oor_sb_empty", 96'(sb.size()), 96'd0);
    tick();

    // Address wrap past 2^32
    bus.i_MEM_wrReady = 1'b0;
    start_frame(32'hFFFF_FFF8);
    add_beat(19'd1, 64'hFEED_FACE_CAFE_BEEF, 1'b1);
    for (int n = 0; n < 10 && !bus.o_MEM_wrValid; n++) tick();
    chk("wrap_wrvalid", 96'(bus.o_MEM_wrValid), 96'd1);
    chk("wrap_wraddr", 96'(bus.o_MEM_wrAddr), 96'd0);
    repeat (2) tick();
    bus.i_MEM_wrReady = 1'b1;
    wait_done("wrap_done", 20);
    tick();

    // Reset mid-frame with 3 entries queued
    bus.i_MEM_wrReady = 1'b0;
    start_frame(32'h4000_0000);
    add_beat(19'd7, 64'h4444_0000_0000_0007, 1'b0);
    add_beat(19'd8, 64'h4444_0000_0000_0008, 1'b0);
    add_beat(19'd9, 64'h4444_0000_0000_0009, 1'b0);
    repeat (6) tick();
    chk("mrst_wrvalid_before", 96'(bus.o_MEM_wrValid), 96'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_wrvalid_async", 96'(bus.o_MEM_wrValid), 96'd0);
    chk("mrst_busy_async", 96'(bus.o_CTRL_busy), 96'd0);
    src_q.delete();
    sb.delete();
    prev_stall = 1'b0;
    bus.i_SIU_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_MEM_wrReady = 1'b1;
    wr_cnt = 0;
    repeat (10) tick();
    chk("mrst_no_writes", 96'(wr_cnt), 96'd0);
    chk("mrst_wrvalid_after", 96'(bus.o_MEM_wrValid), 96'd0);
    chk("mrst_busy_after", 96'(bus.o_CTRL_busy), 96'd0);
    start_frame(32'h5000_0000);
    add_beat(19'd2, 64'h5555_0000_0000_0002, 1'b1);
    wait_done("mrst_new_frame_done", 20);
    chk("mrst_new_writes", 96'(wr_cnt), 96'd1);
    chk("mrst_new_pcount", 96'(bus.o_CTRL_pointCount), 96'd1);
    chk("mrst_sb_empty", 96'(sb.size()), 96'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
